depar_out_arb: RTL and testbench
================================

# depar_out_arb

Packet-atomic round-robin arbiter sharing one AXI4-Stream egress among two deparser instances (two `deparser_top` outputs). It is placed between the deparsers and the output queues. It grants one requester per packet and forwards beats through a single registered output stage until `tlast`. It never interleaves beats of different packets.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, 512, tdata width
- `C_AXIS_TUSER_WIDTH`, 128, tuser width
- `C_CNT_WIDTH`, 32, statistics counter width

Ports:
- `axis_clk`  in  1  sole clock
- `aresetn`  in  1  asynchronous active-low reset
- `s0_axis_tdata` / `s1_axis_tdata`  in  C_AXIS_DATA_WIDTH  requester data
- `s0_axis_tkeep` / `s1_axis_tkeep`  in  C_AXIS_DATA_WIDTH/8  byte enables
- `s0_axis_tuser` / `s1_axis_tuser`  in  C_AXIS_TUSER_WIDTH  metadata; only the first beat is meaningful
- `s0_axis_tvalid` / `s1_axis_tvalid`  in  1  beat valid
- `s0_axis_tlast` / `s1_axis_tlast`  in  1  last beat
- `s0_axis_tready` / `s1_axis_tready`  out  1  beat accepted when valid&ready
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser`, `m_axis_tlast`  out  widths as above  merged stream
- `m_axis_tvalid`  out  1
- `m_axis_tready`  in  1
- `pkt_cnt_0`, `pkt_cnt_1`  out  C_CNT_WIDTH  packets forwarded per port
- `cnt_clr`  in  1  synchronous clear of the counters

## Operation
- The output stage is one register set (`m_*`). `ld = ~m_axis_tvalid | m_axis_tready`.
- State machine `IDLE` / `PASS`, with registers `grant` (1 bit) and `last_grant` (1 bit).
- In `IDLE`:
  - Combinational pick: if only one requester is valid, pick that port.
  - If both are valid, pick `~last_grant`.
  - If `ld` is high, the picked port's tready is 1 and its first beat is loaded the same cycle.
  - If the accepted beat has `tlast`, stay in `IDLE` and set `last_grant`=pick.
  - Otherwise go to `PASS` with `grant`=pick.
- In `PASS`:
  - `sN_axis_tready = (grant==N) & ld`. The other port's tready is 0.
  - Each accepted beat loads `m_*`.
  - On an accepted beat with `tlast`, go to `IDLE` and set `last_grant`=`grant`.
- When `ld` is high and no beat is accepted, `m_axis_tvalid` drops to 0. The data registers may hold stale values.
- tkeep and tuser pass through unmodified. There is no width conversion.
- Reset values: state `IDLE`, `grant`=0, `last_grant`=1 (so port 0 wins the first tie), all `m_*` = 0, both treadies 0, counters 0.

## Timing
- Latency is 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput is 1 beat per cycle while `m_axis_tready` is 1, including back-to-back packets from alternating ports. There is no inter-packet bubble.
- Treadies depend combinationally on `m_axis_tready`. There is no combinational path from input to output data.
- With `m_axis_tready`=0 and `m_axis_tvalid`=1, `m_*` holds stable and both treadies are 0.
- A requester that deasserts tvalid mid-packet keeps its grant. The other port is blocked until the granted packet's tlast.
- Reset asserted mid-packet drops the partial packet. After reset, arbitration restarts in `IDLE`.

## Configuration
- `DEPAR_OUT_ARB_STATS_EN` defined:
  - `pkt_cnt_N` increments by 1 on each accepted tlast beat from port N, wrapping modulo 2^C_CNT_WIDTH.
  - `cnt_clr` zeroes both counters and has priority over an increment in the same cycle.
- Not defined: counters are not built, `pkt_cnt_0`/`pkt_cnt_1` are tied to 0 and `cnt_clr` is ignored.

## Test plan
- Single port: after reset, s0 sends a 3-beat packet and `m_axis_tready`=1 -> m beats appear 1 cycle later, identical tdata/tkeep/tuser, tlast on beat 3; `s1_axis_tready` stays 0.
- Tie: s0 and s1 both hold 2-beat packets, tready=1 -> output order s0,s0,s1,s1,s0,s0,... with no idle cycle between packets.
- Backpressure: hold `m_axis_tready`=0 for 4 cycles mid-packet -> `m_*` stable, both treadies 0, no beat lost or duplicated after release.
- Atomicity: s0 deasserts tvalid for 3 cycles mid-packet while s1 is valid -> `s1_axis_tready` stays 0 until s0's tlast is accepted; s1 is granted next.
- Reset mid-packet: assert `aresetn`=0 during beat 2 of 4 -> `m_axis_tvalid`=0 immediately; after release, the next tie goes to port 0.
- Stats (macro defined): 5 packets on s0 and 3 on s1 -> `pkt_cnt_0`=5, `pkt_cnt_1`=3; `cnt_clr` in the same cycle as a tlast -> counter reads 0. Counter preset to 2^C_CNT_WIDTH-1 -> wraps to 0 on the next packet.

Source files
------------

// File: rtl/depar_out_arb.sv
// Packet-atomic round-robin arbiter merging two deparser AXI4-Stream outputs into one registered egress.
// Optional per-port packet counters are built when DEPAR_OUT_ARB_STATS_EN is defined.
module depar_out_arb #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_CNT_WIDTH        = 32
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt_0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt_1,
  input  logic                            cnt_clr
);

  localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic {IDLE, PASS} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;

  logic ld;
  logic pick;
  logic sel;
  logic en;
  logic sel_valid;
  logic sel_last;
  logic acc;

  // Port selection and handshake: pick is only consulted in IDLE, PASS follows the held grant.
  always_comb begin
    ld        = ~m_axis_tvalid | m_axis_tready;
    pick      = 1'b0;
    if (s0_axis_tvalid && s1_axis_tvalid) pick = ~last_grant;
    else                                  pick = s1_axis_tvalid;
    sel       = (state == PASS) ? grant : pick;
    en        = aresetn & ld & ((state == PASS) | s0_axis_tvalid | s1_axis_tvalid);
    s0_axis_tready = en & ~sel;
    s1_axis_tready = en & sel;
    sel_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
    sel_last  = sel ? s1_axis_tlast  : s0_axis_tlast;
    acc       = en & sel_valid;
  end

  // Arbitration state and the single output register stage.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= KEEP_W'(0);
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (ld) begin
        m_axis_tvalid <= acc;
        if (acc) begin
          m_axis_tdata <= sel ? s1_axis_tdata : s0_axis_tdata;
          m_axis_tkeep <= sel ? s1_axis_tkeep : s0_axis_tkeep;
          m_axis_tuser <= sel ? s1_axis_tuser : s0_axis_tuser;
          m_axis_tlast <= sel_last;
        end
      end
      case (state)
        IDLE: begin
          if (acc) begin
            if (sel_last) begin
              last_grant <= sel;
            end else begin
              state <= PASS;
              grant <= sel;
            end
          end
        end
        PASS: begin
          if (acc && sel_last) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEPAR_OUT_ARB_STATS_EN
  // Packets counted on the accepted tlast beat; clear wins over a same-cycle increment.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
    end else if (cnt_clr) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
    end else if (acc && sel_last) begin
      if (sel) pkt_cnt_1 <= pkt_cnt_1 + C_CNT_WIDTH'(1);
      else     pkt_cnt_0 <= pkt_cnt_0 + C_CNT_WIDTH'(1);
    end
  end
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign pkt_cnt_0 = '0;
  assign pkt_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_depar_out_arb.sv
// Bench for depar_out_arb: directed and random traffic checked against a packet-level queue model.
module tb_depar_out_arb;

  localparam int unsigned DW = 64;
  localparam int unsigned UW = 16;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned CW = 3;
  localparam int unsigned CMASK = (1 << CW) - 1;
`ifdef DEPAR_OUT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0, m_tkeep;
  logic [UW-1:0] s0_tuser = '0, s1_tuser = '0, m_tuser;
  logic s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic s0_tready, s1_tready, m_tlast, m_tvalid;
  logic m_tready = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;

  always #5 clk = ~clk;

  depar_out_arb #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_CNT_WIDTH(CW)) dut (
    .axis_clk(clk), .aresetn(aresetn),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .cnt_clr(cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  // Source traffic, output-register model and packet-level arbitration model.
  beat_t src0[$];
  beat_t src1[$];
  beat_t out_q[$];
  int    owner = -1;
  int    last_w = 1;
  int    cnt[2] = '{0, 0};
  bit    hold[2] = '{0, 0};
  int    stall[2] = '{0, 0};
  int    gap_pct[2] = '{0, 0};
  int    mrdy_gap = 0;
  int    mrdy_low = 0;
  bit    clr_on_last = 1'b0;
  int    seqn = 0;
  int    cyc = 0;
  int    log_port[$];
  int    log_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {8'(p), 24'(seqn), 32'($urandom)};
      b.keep = KW'($urandom_range(255, 1));
      b.user = UW'($urandom);
      b.last = (i == n - 1);
      seqn++;
      if (p == 0) src0.push_back(b); else src1.push_back(b);
    end
  endtask

  function automatic int src_size(input int p);
    return (p == 0) ? src0.size() : src1.size();
  endfunction

  task automatic model_clear();
    src0.delete(); src1.delete(); out_q.delete();
    owner = -1; last_w = 1; cnt = '{0, 0};
    hold = '{0, 0}; stall = '{0, 0};
  endtask

  // One clock: drive at negedge, compare and advance the model before the posedge.
  task automatic cycle();
    bit    v[2];
    bit    room;
    int    w;
    beat_t b;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (hold[p]) v[p] = 1'b1;
      else if (stall[p] > 0) begin v[p] = 1'b0; stall[p]--; end
      else v[p] = (src_size(p) != 0) && ($urandom_range(99) >= 32'(gap_pct[p]));
    end
    s0_tvalid = v[0];
    s1_tvalid = v[1];
    if (src0.size() != 0) {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = src0[0];
    if (src1.size() != 0) {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = src1[0];
    if (mrdy_low > 0) begin m_tready = 1'b0; mrdy_low--; end
    else m_tready = ($urandom_range(99) >= 32'(mrdy_gap));
    #1;
    chk("m_tvalid", 64'(m_tvalid), 64'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      chk("m_tdata", m_tdata, out_q[0].data);
      chk("m_tkeep", 64'(m_tkeep), 64'(out_q[0].keep));
      chk("m_tuser", 64'(m_tuser), 64'(out_q[0].user));
      chk("m_tlast", 64'(m_tlast), 64'(out_q[0].last));
    end
    chk("pkt_cnt_0", 64'(pkt_cnt_0), 64'(cnt[0]));
    chk("pkt_cnt_1", 64'(pkt_cnt_1), 64'(cnt[1]));
    room = (out_q.size() == 0) || m_tready;
    if (owner >= 0) w = owner;
    else if (v[0] && v[1]) w = 1 - last_w;
    else if (v[1]) w = 1;
    else if (v[0]) w = 0;
    else w = -1;
    chk("s0_tready", 64'(s0_tready), 64'(room && w == 0));
    chk("s1_tready", 64'(s1_tready), 64'(room && w == 1));
    if (out_q.size() != 0 && m_tready) begin
      log_port.push_back(int'(m_tdata[DW-1 -: 8]));
      log_cyc.push_back(cyc);
      void'(out_q.pop_front());
    end
    hold[0] = v[0];
    hold[1] = v[1];
    if (w >= 0 && room && v[w]) begin
      hold[w] = 1'b0;
      b = (w == 0) ? src0.pop_front() : src1.pop_front();
      out_q.push_back(b);
      if (b.last) begin
        owner = -1;
        last_w = w;
        if (clr_on_last) cnt_clr = 1'b1;
        else if (STATS) cnt[w] = (cnt[w] + 1) & CMASK;
      end else owner = w;
    end
    if (cnt_clr && STATS) cnt = '{0, 0};
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || out_q.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(n < maxc), 64'(1));
  endtask

  // Asserts reset now, checks the output drops at once, then restarts from an empty model.
  task automatic reset_now();
    aresetn = 1'b0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", m_tdata, 64'(0));
    repeat (2) @(negedge clk);
    model_clear();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0; cnt_clr = 1'b0;
    #1;
    chk("rst_s0_tready", 64'(s0_tready), 64'(0));
    chk("rst_s1_tready", 64'(s1_tready), 64'(0));
    chk("rst_cnt0", 64'(pkt_cnt_0), 64'(0));
    chk("rst_cnt1", 64'(pkt_cnt_1), 64'(0));
    aresetn = 1'b1;
  endtask

  initial begin
    // Reset state
    reset_now();
    log_port.delete(); log_cyc.delete();

    // Single port, 3-beat packet
    add_pkt(0, 3);
    drain(50);
    chk("single_beats", 64'(log_port.size()), 64'(3));
    if (log_port.size() == 3) chk("single_gapless", 64'(log_cyc[2] - log_cyc[0]), 64'(2));

    // Tie after reset: alternating 2-beat packets with no bubble
    @(negedge clk);
    reset_now();
    log_port.delete(); log_cyc.delete();
    for (int i = 0; i < 3; i++) begin add_pkt(0, 2); add_pkt(1, 2); end
    drain(100);
    chk("tie_beats", 64'(log_port.size()), 64'(12));
    for (int i = 0; i < log_port.size() && i < 12; i++) begin
      chk($sformatf("tie_port%0d", i), 64'(log_port[i]), 64'((i / 2) % 2));
      chk($sformatf("tie_cyc%0d", i), 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end

    // Backpressure mid-packet
    log_port.delete(); log_cyc.delete();
    add_pkt(0, 4);
    cycle(); cycle();
    mrdy_low = 4;
    drain(50);
    chk("bp_beats", 64'(log_port.size()), 64'(4));

    // Atomicity: s0 stalls mid-packet while s1 waits
    log_port.delete(); log_cyc.delete();
    add_pkt(0, 4); add_pkt(1, 2);
    stall[1] = 1;
    cycle();
    stall[0] = 3;
    drain(60);
    chk("atom_beats", 64'(log_port.size()), 64'(6));
    for (int i = 0; i < log_port.size() && i < 6; i++)
      chk($sformatf("atom_port%0d", i), 64'(log_port[i]), 64'(i >= 4));

    // Reset during beat 2 of 4, then a tie must go to port 0
    add_pkt(0, 4);
    cycle(); cycle();
    @(negedge clk);
    #2;
    reset_now();
    log_port.delete(); log_cyc.delete();
    add_pkt(1, 1); add_pkt(0, 1);
    drain(20);
    if (log_port.size() == 2) chk("post_rst_tie", 64'(log_port[0]), 64'(0));
    else chk("post_rst_beats", 64'(log_port.size()), 64'(2));

    // Counters: 5 + 3 packets, clear on a tlast cycle, wrap
    @(negedge clk);
    reset_now();
    for (int i = 0; i < 5; i++) add_pkt(0, 2);
    for (int i = 0; i < 3; i++) add_pkt(1, 1);
    drain(100);
    cycle();
    chk("stats_cnt0", 64'(pkt_cnt_0), STATS ? 64'(5) : 64'(0));
    chk("stats_cnt1", 64'(pkt_cnt_1), STATS ? 64'(3) : 64'(0));
    clr_on_last = 1'b1;
    add_pkt(0, 1);
    drain(20);
    clr_on_last = 1'b0;
    cycle();
    chk("clr_on_tlast", 64'(pkt_cnt_0), 64'(0));
    for (int i = 0; i < 7; i++) add_pkt(1, 1);
    drain(50);
    cycle();
    chk("cnt1_max", 64'(pkt_cnt_1), STATS ? 64'(CMASK) : 64'(0));
    add_pkt(1, 1);
    drain(20);
    cycle();
    chk("cnt1_wrap", 64'(pkt_cnt_1), 64'(0));

    // Random traffic with gaps and backpressure
    gap_pct = '{30, 30};
    mrdy_gap = 30;
    for (int i = 0; i < 40; i++) begin
      add_pkt(0, int'($urandom_range(5, 1)));
      add_pkt(1, int'($urandom_range(5, 1)));
    end
    drain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
